// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  // funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_e;

  // Cycles beyond DATA_W iteration steps: PREP, FIX and DONE
  localparam int MULDIV_LAT_EXTRA = 3;

  function automatic logic is_div(input op_e op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
  function automatic logic a_is_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MUL, MULH, DIV, REM
  function automatic logic b_is_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One combinational radix-2 step shared by multiply and divide.
// Accumulator layout is {hi, lo}, each DATA_W bits.
//   multiply: lo holds the remaining multiplier bits, hi the partial product;
//             add the multiplicand when lo[0] is set, then shift right.
//   divide:   hi holds the partial remainder, lo the dividend bits being
//             shifted out and quotient bits being shifted in.
module muldiv_iter_step #(
  parameter int DATA_W = 64
) (
  input  logic                  i_div,
  input  logic [2*DATA_W-1:0]   i_acc,
  input  logic [DATA_W-1:0]     i_op_b,
  output logic [2*DATA_W-1:0]   o_acc
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W+1:0] w_diff;
  logic              w_unused_msb;

  // The trial difference never exceeds the divisor when it succeeds, so its
  // bit DATA_W is always zero on the path that keeps it.
  assign w_unused_msb = w_diff[DATA_W];

  // Select between the shift-add and the trial-subtract step
  always_comb begin
    w_sum  = {1'b0, i_acc[2*DATA_W-1:DATA_W]} + (i_acc[0] ? {1'b0, i_op_b} : '0);
    w_diff = {1'b0, i_acc[2*DATA_W-1:DATA_W-1]} - {2'b00, i_op_b};
    o_acc  = {w_sum, i_acc[DATA_W-1:1]};
    if (i_div) begin
      if (!w_diff[DATA_W+1]) begin
        o_acc = {w_diff[DATA_W-1:0], i_acc[DATA_W-2:0], 1'b1};
      end else begin
        o_acc = {i_acc[2*DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage.
// Optional build macro MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed
// overflow finish straight from PREP instead of running all iterations.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [4:0]        rd_in,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [4:0]        rd_out
);

  localparam logic [5:0]        LAST_STEP = 6'(DATA_W - 1);
  localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  state_e              r_state;
  op_e                 r_op;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_mag_b;
  logic [2*DATA_W-1:0] r_acc;
  logic [5:0]          r_cnt;
  logic [4:0]          r_rd;
  logic                r_neg_q;
  logic                r_neg_r;

  logic                w_a_neg;
  logic                w_b_neg;
  logic [DATA_W-1:0]   w_mag_a;
  logic [DATA_W-1:0]   w_mag_b;
  logic                w_div0;
  logic                w_ovf;
  logic                w_special;
  logic [DATA_W-1:0]   w_special_res;
  logic [2*DATA_W-1:0] w_step_acc;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quot;
  logic [DATA_W-1:0]   w_rem;
  logic [DATA_W-1:0]   w_final;

  // Magnitudes and signs of the captured raw operands
  always_comb begin
    w_a_neg = a_is_signed(r_op) & r_a[DATA_W-1];
    w_b_neg = b_is_signed(r_op) & r_b[DATA_W-1];
    w_mag_a = w_a_neg ? -r_a : r_a;
    w_mag_b = w_b_neg ? -r_b : r_b;
  end

  // RISC-V mandated results for x/0 and MOST_NEG/-1, from the raw operands
  always_comb begin
    w_div0        = is_div(r_op) && (r_b == '0);
    w_ovf         = is_div(r_op) && b_is_signed(r_op) && (r_a == MOST_NEG) && (&r_b);
    w_special     = w_div0 | w_ovf;
    w_special_res = r_a;
    if (w_div0) begin
      w_special_res = r_op[1] ? r_a : '1;
    end else if (w_ovf) begin
      w_special_res = r_op[1] ? '0 : r_a;
    end
  end

  muldiv_iter_step #(.DATA_W(DATA_W)) u_step (
    .i_div  (is_div(r_op)),
    .i_acc  (r_acc),
    .i_op_b (r_mag_b),
    .o_acc  (w_step_acc)
  );

  // Sign correction, half selection and special-case override
  always_comb begin
    w_prod  = r_neg_q ? -r_acc : r_acc;
    w_quot  = r_neg_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    w_rem   = r_neg_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    w_final = w_prod[2*DATA_W-1:DATA_W];
    if (w_special) begin
      w_final = w_special_res;
    end else if (is_div(r_op)) begin
      w_final = r_op[1] ? w_rem : w_quot;
    end else if (r_op == OP_MUL) begin
      w_final = w_prod[DATA_W-1:0];
    end
  end

  // Control FSM with registered busy/done/result/rd_out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= OP_MUL;
      r_a     <= '0;
      r_b     <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_rd    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= ST_PREP;
            busy    <= 1'b1;
            r_op    <= op_e'(op);
            r_a     <= operand_a;
            r_b     <= operand_b;
            r_rd    <= rd_in;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PREP: begin
          // Both algorithms start from {0, |a|}
          r_acc   <= {{DATA_W{1'b0}}, w_mag_a};
          r_mag_b <= w_mag_b;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          r_cnt   <= '0;
`ifdef MULDIV_FAST_SPECIAL_EN
          if (w_special) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= w_final;
            rd_out  <= r_rd;
          end else begin
            r_state <= ST_ITER;
          end
`else
          r_state <= ST_ITER;
`endif
        end
        ST_ITER: begin
          r_acc <= w_step_acc;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_STEP) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_state <= ST_DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          result  <= w_final;
          rd_out  <= r_rd;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (DATA_W = 64): directed cases from
// the test plan followed by random operations against a reference model.
module tb_ex_muldiv_unit;

  localparam logic [63:0] MIN64  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [63:0] operand_a = '0;
  logic [63:0] operand_b = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] last_res = '0;
  logic [4:0]  last_rd  = '0;

  ex_muldiv_unit #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: RISC-V M semantics with wide plain arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] ea_s, eb_s, ea_u, eb_u, p;
    logic signed [63:0] sa, sb;
    ea_s = {{64{a[63]}}, a};
    eb_s = {{64{b[63]}}, b};
    ea_u = {64'd0, a};
    eb_u = {64'd0, b};
    sa = a;
    sb = b;
    case (o)
      3'd0: begin p = ea_u * eb_u; return p[63:0]; end
      3'd1: begin p = ea_s * eb_s; return p[127:64]; end
      3'd2: begin p = ea_s * eb_u; return p[127:64]; end
      3'd3: begin p = ea_u * eb_u; return p[127:64]; end
      3'd4: begin
        if (b == 0) return ONES64;
        if (a == MIN64 && b == ONES64) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? ONES64 : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == MIN64 && b == ONES64) return 64'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_FAST_SPECIAL_EN
    logic sp;
    sp = o[2] && ((b == 0) || (!o[0] && a == MIN64 && b == ONES64));
    return sp ? 2 : 67;
`else
    return (o[2] && a == b) ? 67 : 67;
`endif
  endfunction

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return MIN64;
      2: return ONES64;
      3: return 64'($signed($urandom_range(0, 20)) - 10);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Start request in the current cycle; returns in cycle 1 with inputs scrambled
  task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] rd);
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    rd_in     = rd;
    step();
    start     = 1'b0;
    op        = 3'($urandom);
    operand_a = {$urandom, $urandom};
    operand_b = {$urandom, $urandom};
    rd_in     = 5'($urandom);
  endtask

  // Wait (bounded) for done; returns in the done cycle
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp);
    int lat;
    logic busy_ok;
    logic [4:0] rd;
    rd = 5'($urandom);
    issue(o, a, b, rd);
    wait_done(lat, busy_ok);
    chk({tag, " latency"}, 128'(lat), 128'(exp_lat(o, a, b)));
    chk({tag, " busy"}, 128'(busy_ok), 128'(1));
    chk({tag, " result"}, 128'(result), 128'(exp));
    chk({tag, " rd_out"}, 128'(rd_out), 128'(rd));
    chk({tag, " busy_in_done"}, 128'(busy), 128'(0));
    last_res = exp;
    last_rd  = rd;
    $display("%s op=%0d a=%h b=%h rd=%0d result=%h cycles=%0d", tag, o, a, b, rd, result, lat);
  endtask

  initial begin
    logic [2:0]  r_o;
    logic [63:0] r_a, r_b;

    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset result", 128'(result), 128'(0));
    chk("reset rd_out", 128'(rd_out), 128'(0));
    rst = 1'b0;
    step();

    // Directed cases
    run_op("mul_7_m3", 3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
    step();
    chk("mul done_pulse", 128'(done), 128'(0));
    run_op("mulhu_ones", 3'd3, ONES64, ONES64, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    run_op("mulh_ones", 3'd1, ONES64, ONES64, 64'd0);
    step();
    // Back-to-back: REM issued in the DIV done cycle
    run_op("div_m7_2", 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("rem_m7_2_b2b", 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES64);
    step();
    run_op("divu_5_0", 3'd5, 64'd5, 64'd0, ONES64);
    step();
    run_op("remu_5_0", 3'd7, 64'd5, 64'd0, 64'd5);
    step();
    run_op("div_ovf", 3'd4, MIN64, ONES64, MIN64);
    step();
    run_op("rem_ovf", 3'd6, MIN64, ONES64, 64'd0);
    step();

    // Flush in cycle 10 of a DIV
    issue(3'd4, 64'd1000, 64'd7, 5'd9);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", 128'(busy), 128'(0));
    chk("flush done", 128'(done), 128'(0));
    chk("flush result_kept", 128'(result), 128'(last_res));
    chk("flush rd_kept", 128'(rd_out), 128'(last_rd));
    run_op("after_flush", 3'd5, 64'd100, 64'd7, 64'd14);
    step();

    // Reset in cycle 10 of a DIV
    issue(3'd4, 64'd1000, 64'd7, 5'd9);
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst busy", 128'(busy), 128'(0));
    chk("rst done", 128'(done), 128'(0));
    chk("rst result", 128'(result), 128'(0));
    chk("rst rd_out", 128'(rd_out), 128'(0));
    run_op("after_rst", 3'd7, 64'd100, 64'd7, 64'd2);
    step();

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      r_o = 3'($urandom_range(0, 7));
      r_a = pick_operand();
      r_b = pick_operand();
      run_op("rand", r_o, r_a, r_b, ref_model(r_o, r_a, r_b));
      if ($urandom_range(0, 1) == 0) begin
        step();
        chk("rand done_pulse", 128'(done), 128'(0));
      end
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
# ex_muldiv_unit

Iterative RV64M multiply/divide execution unit, parametrised in data width. Sits beside the single-cycle ALU in the EX stage of the 5-stage pipeline. Accepts one operation at a time and holds `busy` so the hazard logic stalls IF/ID/EX. Returns the result with the destination register tag for the EX/MEM register.

## Interface
- `DATA_W`, 64: operand/result width, 32 or 64.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request; sampled only when state is IDLE or DONE.
- `op` input 3: funct3 code. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `operand_a` input DATA_W: rs1 value, after forwarding.
- `operand_b` input DATA_W: rs2 value, after forwarding.
- `rd_in` input 5: destination register tag.
- `flush` input 1: kill the in-flight operation (branch/jump squash).
- `busy` output 1: operation in progress; the pipeline stalls while high.
- `done` output 1: one-cycle pulse, result valid.
- `result` output DATA_W: result; holds its value until the next `done`.
- `rd_out` output 5: tag captured at start; holds like `result`.

## Operation
- FSM states:
  - IDLE: start→PREP.
  - PREP: capture operand magnitudes and the result sign; go to ITER.
  - ITER: DATA_W steps, 6-bit step counter; on the last step go to FIX.
  - FIX: apply sign correction and special-case override; go to DONE.
  - DONE: `done`=1; start→PREP, else IDLE.
- Operand signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Multiply: radix-2 shift-add on magnitudes into a 2·DATA_W accumulator. Negate in FIX if the signs differ. MUL returns the low half; the MULH variants return the high half.
- Divide: restoring division on magnitudes. Quotient is negated if the signs differ. Remainder takes the dividend's sign.
- Special cases (RISC-V spec, mandatory):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - Both are overridden in FIX, independent of the sign logic.
- `flush` has priority over everything except `rst`. The state goes to IDLE on the next edge, with no `done`. `result` and `rd_out` are unchanged.
- `start` in the same cycle as `flush` is dropped.
- `start` in PREP/ITER/FIX is ignored. The pipeline never issues it there.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `rd_out` 0, counter 0.
- Start sampled in cycle 0:
  - PREP is cycle 1.
  - ITER is cycles 2..DATA_W+1.
  - FIX is cycle DATA_W+2.
  - DONE (`done`=1) is cycle DATA_W+3: cycle 67 for DATA_W=64, cycle 35 for DATA_W=32.
- `busy` is 1 in PREP, ITER and FIX; 0 in IDLE and DONE.
- Back-to-back operation: `start` in a DONE cycle enters PREP in the next cycle. Throughput is one operation per DATA_W+3 cycles.
- `result`/`rd_out` are registered on entry to DONE, so they are stable in the `done` cycle.
- `rst` during any state returns to the reset values on the next edge.

## Configuration
- `MULDIV_FAST_SPECIAL_EN`:
  - Defined: divide-by-zero and signed overflow are detected in PREP and jump directly to DONE with the override result. `done` is in cycle 2. Multiply is unaffected.
  - Undefined: the special cases run full latency; override in FIX; `done` is in cycle DATA_W+3.
  - Results are identical either way.

## Structure
- `muldiv_pkg`:
  - op encoding enum (funct3 values).
  - FSM state enum.
  - `MULDIV_LAT_EXTRA` = 3.
  - helper function `is_div(op)`.
- Sub-module `muldiv_iter_step`: combinational single step with a mode input. Multiply = conditional add + shift; divide = trial subtract + shift-in of the quotient bit. Instantiated once and driven by the FSM registers.

## Test plan
- MUL a=7, b=-3 → `result`=0xFFFF_FFFF_FFFF_FFEB, `rd_out`=`rd_in`, `done` in cycle 67 only, `busy` 1 in cycles 1..66.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands → 0.
- DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD. REM -7/2 → 0xFFFF_FFFF_FFFF_FFFF. Issued back-to-back: the second `done` comes exactly 67 cycles after the first.
- DIVU 5/0 → all ones. REMU 5/0 → 5. `done` in cycle 67, or cycle 2 with `MULDIV_FAST_SPECIAL_EN`.
- DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000. REM with the same operands → 0.
- `flush` in cycle 10 of a DIV → `busy`=0 in cycle 11, no `done`, previous `result` kept. A new `start` in cycle 11 completes normally. Repeat the scenario with `rst` in place of `flush` → all outputs 0.
